// File: rtl/pkt_commit_fifo_pkg.sv
// Shared definitions for the packet commit FIFO: default widths and write FSM states.
package pkt_commit_fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 64;
    localparam int unsigned CTRL_WIDTH_DEF = DATA_WIDTH_DEF / 8;
    localparam int unsigned ADDR_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_IN_PKT   = 2'b01,
        ST_OVERFLOW = 2'b10
    } wr_state_e;

endpackage

// File: rtl/pkt_commit_fifo_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
module pkt_commit_ram #(
    parameter int unsigned WIDTH      = 72,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [WIDTH-1:0] rdata_q;

    // Storage write; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; output register is cleared on reset and holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_commit_fifo.sv
// Packet-granular output buffer: words become readable only once their packet
// commits; dropped, overflowed or abandoned packets are erased by rewinding wr_ptr.
module pkt_commit_fifo
    import pkt_commit_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  in_drop,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [31:0]           pkts_committed,
    output logic [31:0]           pkts_dropped
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PW-1:0] TWO   = {{(PW-2){1'b0}}, 2'b10};

    wr_state_e       st_q, st_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   commit_q, commit_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [31:0]     committed_q, committed_d;
    logic [31:0]     dropped_q, dropped_d;
    logic            in_rdy_q, in_rdy_d;
    logic            out_wr_q;

    logic [PW-1:0]   used;
    logic            full;
    logic            commit_full;
    logic            rd_issue;
    logic            start;
    logic            n_commit;
    logic [1:0]      n_drop;
    logic            ram_we;
    logic [PW-1:0]   ram_waddr;

    assign used        = wr_q - rd_q;
    assign full        = (used == DEPTH);
    assign commit_full = ((commit_q - rd_q) == DEPTH);
    assign rd_issue    = (commit_q != rd_q) && out_rdy;
    assign in_rdy_d    = (DEPTH - used) > TWO;

    // Write-side next state: packet start, continuation, resolution and rewinds.
    always_comb begin
        st_d      = st_q;
        wr_d      = wr_q;
        commit_d  = commit_q;
        n_commit  = 1'b0;
        n_drop    = 2'd0;
        ram_we    = 1'b0;
        ram_waddr = wr_q;
        start     = 1'b0;

        if (in_wr) begin
            unique case (st_q)
                ST_IDLE: begin
                    start = in_first;
                end
                ST_IN_PKT: begin
                    if (in_first) begin
                        n_drop = n_drop + 2'd1;
                        wr_d   = commit_q;
                        start  = 1'b1;
                    end else if (full) begin
                        if (in_last) begin
                            wr_d   = commit_q;
                            n_drop = n_drop + 2'd1;
                            st_d   = ST_IDLE;
                        end else begin
                            st_d = ST_OVERFLOW;
                        end
                    end else begin
                        ram_we    = 1'b1;
                        ram_waddr = wr_q;
                        wr_d      = wr_q + ONE;
                        if (in_last) begin
                            st_d = ST_IDLE;
                            if (in_drop) begin
                                wr_d   = commit_q;
                                n_drop = n_drop + 2'd1;
                            end else begin
                                commit_d = wr_q + ONE;
                                n_commit = 1'b1;
                            end
                        end
                    end
                end
                ST_OVERFLOW: begin
                    if (in_first || in_last) begin
                        wr_d   = commit_q;
                        n_drop = n_drop + 2'd1;
                        st_d   = ST_IDLE;
                    end
                    start = in_first;
                end
                default: begin
                    st_d = ST_IDLE;
                end
            endcase

            // A new packet always begins at commit_ptr (wr_ptr equals it in IDLE, and
            // abandon/overflow rewind to it first), so space is judged after that rewind.
            if (start) begin
                if (commit_full) begin
                    if (in_last) begin
                        n_drop = n_drop + 2'd1;
                        st_d   = ST_IDLE;
                    end else begin
                        st_d = ST_OVERFLOW;
                    end
                end else begin
                    ram_we    = 1'b1;
                    ram_waddr = commit_q;
                    wr_d      = commit_q + ONE;
                    st_d      = ST_IN_PKT;
                    if (in_last) begin
                        st_d = ST_IDLE;
                        if (in_drop) begin
                            wr_d   = commit_q;
                            n_drop = n_drop + 2'd1;
                        end else begin
                            commit_d = commit_q + ONE;
                            n_commit = 1'b1;
                        end
                    end
                end
            end
        end

        rd_d        = rd_q + {{ADDR_WIDTH{1'b0}}, rd_issue};
        committed_d = committed_q + {31'd0, n_commit};
        dropped_d   = dropped_q + {30'd0, n_drop};
    end

    // State, pointer, counter and handshake registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= ST_IDLE;
            wr_q        <= '0;
            commit_q    <= '0;
            rd_q        <= '0;
            committed_q <= '0;
            dropped_q   <= '0;
            in_rdy_q    <= 1'b0;
            out_wr_q    <= 1'b0;
        end else begin
            st_q        <= st_d;
            wr_q        <= wr_d;
            commit_q    <= commit_d;
            rd_q        <= rd_d;
            committed_q <= committed_d;
            dropped_q   <= dropped_d;
            in_rdy_q    <= in_rdy_d;
            out_wr_q    <= rd_issue;
        end
    end

    pkt_commit_ram #(
        .WIDTH      (CTRL_WIDTH + DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (ram_we),
        .waddr_i (ram_waddr[ADDR_WIDTH-1:0]),
        .wdata_i ({in_ctrl, in_data}),
        .re_i    (rd_issue),
        .raddr_i (rd_q[ADDR_WIDTH-1:0]),
        .rdata_o ({out_ctrl, out_data})
    );

    assign in_rdy         = in_rdy_q;
    assign out_wr         = out_wr_q;
    assign pkts_committed = committed_q;
    assign pkts_dropped   = dropped_q;

endmodule

// File: tb/tb_pkt_commit_fifo.sv
// Scoreboard bench for pkt_commit_fifo: committed words are queued when driven
// and compared as they leave the output port.
module tb_pkt_commit_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        in_drop = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b1;
    logic [31:0] pkts_committed;
    logic [31:0] pkts_dropped;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [71:0] exp_q [$];

    pkt_commit_fifo #(
        .DATA_WIDTH (64),
        .CTRL_WIDTH (8),
        .ADDR_WIDTH (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_ctrl        (in_ctrl),
        .in_wr          (in_wr),
        .in_first       (in_first),
        .in_last        (in_last),
        .in_drop        (in_drop),
        .in_rdy         (in_rdy),
        .out_data       (out_data),
        .out_ctrl       (out_ctrl),
        .out_wr         (out_wr),
        .out_rdy        (out_rdy),
        .pkts_committed (pkts_committed),
        .pkts_dropped   (pkts_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output monitor: every output word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_wr) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", {71'd0, out_wr}, 72'd0);
            end else begin
                check("out_word", {out_ctrl, out_data}, exp_q.pop_front());
            end
        end
    end

    task automatic send_word(input logic first, input logic last, input logic drop,
                             input logic [7:0] ctrl, input logic [63:0] data);
        @(negedge clk);
        in_wr    = 1'b1;
        in_first = first;
        in_last  = last;
        in_drop  = drop;
        in_ctrl  = ctrl;
        in_data  = data;
    endtask

    task automatic idle();
        @(negedge clk);
        in_wr    = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_drop  = 1'b0;
    endtask

    // Whole packet, words base..base+n-1; queued as expected output only if committed.
    task automatic send_pkt(input int unsigned n, input logic drop, input logic [63:0] base);
        for (int unsigned i = 0; i < n; i++) begin
            logic [7:0] c;
            c = (i == 0) ? 8'hFF : 8'h00;
            send_word(i == 0, i == n - 1, (i == n - 1) && drop, c, base + 64'(i));
            if (!drop) exp_q.push_back({c, base + 64'(i)});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_wr = 1'b0;
        in_first = 1'b0;
        in_last = 1'b0;
        in_drop = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("rst_in_rdy", {71'd0, in_rdy}, 72'd0);
        check("rst_out_wr", {71'd0, out_wr}, 72'd0);
        check("rst_committed", {40'd0, pkts_committed}, 72'd0);
        check("rst_dropped", {40'd0, pkts_dropped}, 72'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_rdy", {71'd0, in_rdy}, 72'd1);
    endtask

    task automatic wait_drain();
        int unsigned cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 600) begin
            @(posedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 72'(exp_q.size()), 72'd0);
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: four-word committed packet, output timing and order
        do_reset();
        out_rdy = 1'b1;
        send_pkt(4, 1'b0, 64'd1);
        idle();
        check("t1_no_early_out", {71'd0, out_wr}, 72'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("t1_out_wr_on", {71'd0, out_wr}, 72'd1);
        end
        @(posedge clk);
        #1;
        check("t1_out_wr_off", {71'd0, out_wr}, 72'd0);
        check("t1_committed", {40'd0, pkts_committed}, 72'd1);
        wait_drain();

        // 2: dropped packet leaves no trace, following packet intact
        do_reset();
        send_pkt(4, 1'b1, 64'd1);
        idle();
        repeat (4) @(posedge clk);
        #1;
        check("t2_dropped", {40'd0, pkts_dropped}, 72'd1);
        check("t2_committed0", {40'd0, pkts_committed}, 72'd0);
        check("t2_wr_ptr", {63'd0, dut.wr_q}, 72'd0);
        send_pkt(2, 1'b0, 64'h100);
        idle();
        wait_drain();
        check("t2_committed1", {40'd0, pkts_committed}, 72'd1);

        // 3: single-word packet
        do_reset();
        send_word(1'b1, 1'b1, 1'b0, 8'hFF, 64'hAB);
        exp_q.push_back({8'hFF, 64'hAB});
        idle();
        wait_drain();
        check("t3_committed", {40'd0, pkts_committed}, 72'd1);
        check("t3_dropped", {40'd0, pkts_dropped}, 72'd0);

        // 4: overflow with output stalled, then recovery
        do_reset();
        out_rdy = 1'b0;
        for (int unsigned i = 1; i <= 300; i++) begin
            send_word(i == 1, i == 300, 1'b0, (i == 1) ? 8'hFF : 8'h00, 64'(i));
            if (i == 254) begin
                @(posedge clk);
                #1;
                check("t4_in_rdy_254", {71'd0, in_rdy}, 72'd1);
            end
            if (i == 255) begin
                @(posedge clk);
                #1;
                check("t4_in_rdy_255", {71'd0, in_rdy}, 72'd0);
            end
        end
        idle();
        @(posedge clk);
        #1;
        check("t4_dropped", {40'd0, pkts_dropped}, 72'd1);
        check("t4_committed0", {40'd0, pkts_committed}, 72'd0);
        send_pkt(10, 1'b0, 64'h200);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("t4_stalled_out", {71'd0, out_wr}, 72'd0);
        out_rdy = 1'b1;
        wait_drain();
        check("t4_committed1", {40'd0, pkts_committed}, 72'd1);

        // 5: abandoned packet (new first mid-packet)
        do_reset();
        send_word(1'b1, 1'b0, 1'b0, 8'hFF, 64'h31);
        send_word(1'b0, 1'b0, 1'b0, 8'h00, 64'h32);
        send_word(1'b0, 1'b0, 1'b0, 8'h00, 64'h33);
        send_pkt(2, 1'b0, 64'h50);
        idle();
        wait_drain();
        check("t5_dropped", {40'd0, pkts_dropped}, 72'd1);
        check("t5_committed", {40'd0, pkts_committed}, 72'd1);

        // 6: reset mid-packet with committed packets buffered
        do_reset();
        out_rdy = 1'b0;
        send_pkt(2, 1'b0, 64'h60);
        send_pkt(2, 1'b0, 64'h70);
        send_word(1'b1, 1'b0, 1'b0, 8'hFF, 64'h80);
        send_word(1'b0, 1'b0, 1'b0, 8'h00, 64'h81);
        do_reset();
        out_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_stale_out", {71'd0, out_wr}, 72'd0);
        send_pkt(3, 1'b0, 64'h90);
        idle();
        wait_drain();
        check("t6_committed", {40'd0, pkts_committed}, 72'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_commit_fifo.md
Name: pkt_commit_fifo

Overview:
- Packet-granular output buffer. Sits directly downstream of the IDS matcher stage in the user data path.
- Accepts one word per cycle with first/last markers and a drop verdict sampled on the last word.
- A packet becomes visible to the output only when its last word is written without a drop. Dropped packets are erased by rewinding the write pointer.
- Output side is NetFPGA style: out_wr/out_rdy toward the next stage; counts committed and dropped packets.

Parameters:
- DATA_WIDTH, 64, data bus width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width.
- ADDR_WIDTH, 8, log2 of buffer depth in words (DEPTH = 256).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH  word data
- in_ctrl  in  CTRL_WIDTH  word ctrl, stored alongside data
- in_wr  in  1  word valid
- in_first  in  1  word is first of packet (qualified by in_wr)
- in_last  in  1  word is last of packet (qualified by in_wr)
- in_drop  in  1  drop verdict, sampled only when in_wr && in_last
- in_rdy  out  1  upstream may write next cycle
- out_data  out  DATA_WIDTH  output data
- out_ctrl  out  CTRL_WIDTH  output ctrl
- out_wr  out  1  output word valid
- out_rdy  in  1  downstream can accept (nearly-full semantics, one word of slack)
- pkts_committed  out  32  committed packet count, wraps
- pkts_dropped  out  32  dropped packet count (verdict, overflow or abandon), wraps

Behaviour:
- Pointers:
  - wr_ptr, commit_ptr, rd_ptr are each ADDR_WIDTH+1 bits; the MSB distinguishes full from empty.
  - used = wr_ptr - rd_ptr (modulo arithmetic).
  - full = (used == DEPTH).
  - committed words available = commit_ptr - rd_ptr.
- in_rdy = (DEPTH - used) > 2, registered.
- Write FSM states: IDLE, IN_PKT, OVERFLOW.
  - IDLE:
    - in_wr && in_first → write word, wr_ptr+1, go IN_PKT.
    - If in_last is also set (single-word packet), resolve the commit immediately and stay IDLE.
    - in_wr without in_first → word discarded, no change.
  - IN_PKT:
    - in_wr → write word, wr_ptr+1.
    - in_wr && in_first (new packet before last) → abandon: wr_ptr ← commit_ptr, then write the new word at commit_ptr; pkts_dropped+1; stay IN_PKT.
  - Any state, write while full → word discarded, go OVERFLOW.
  - OVERFLOW: discard words. On in_last → wr_ptr ← commit_ptr, pkts_dropped+1, go IDLE. in_first → same rewind and drop count, then treat the word as in IDLE.
- Resolution on in_wr && in_last while in IN_PKT (or the IDLE single-word case):
  - !in_drop → commit_ptr ← wr_ptr+1, pkts_committed+1.
  - in_drop → wr_ptr ← commit_ptr, pkts_dropped+1.
  - Go IDLE.
- Read side:
  - Issue a read when (commit_ptr != rd_ptr) && out_rdy, then rd_ptr+1.
  - RAM latency is 1, so out_wr is asserted the cycle after the issue with out_data/out_ctrl valid. Maximum one word per cycle, back-to-back.
  - out_wr is never asserted for uncommitted words.
- Simultaneous read and write in the same cycle is legal. full/used use the pre-update pointers; a read frees space one cycle later.
- Reset (any time, including mid-packet): all pointers 0, state IDLE, out_wr 0, out_data/out_ctrl 0, counters 0, in_rdy 0 in the reset cycle and 1 after. Buffer contents are discarded.
- Counters wrap modulo 2^32 and never saturate.

Decomposition:
- Shared package holds:
  - width constants: DATA_WIDTH, CTRL_WIDTH, ADDR_WIDTH defaults;
  - write FSM state encoding: IDLE=2'b00, IN_PKT=2'b01, OVERFLOW=2'b10.
- One sub-module, pkt_commit_ram: simple dual-port RAM, width CTRL_WIDTH+DATA_WIDTH, depth 2^ADDR_WIDTH, registered read, one write and one read port.

Test Plan:
- 4-word packet (ctrl FF,00,00,00; data 1..4), in_drop=0, out_rdy=1 → out_wr for 4 consecutive cycles, the first beginning 2 cycles after the last input word; data 1..4 in order; pkts_committed=1.
- Same 4-word packet with in_drop=1 on the last word → out_wr never asserted; pkts_dropped=1; wr_ptr returns to 0; a following committed 2-word packet appears at the output intact.
- Single-word packet (in_first=in_last=1, data 0xAB) → exactly one out_wr with 0xAB; pkts_committed=1.
- out_rdy=0 while a 300-word packet is written → in_rdy falls at used=254; forced writes past 256 are discarded; at last word pkts_dropped=1, no output. Then a 10-word packet commits and drains once out_rdy=1.
- in_first arrives mid-packet after 3 words, then a 2-word packet completes → pkts_dropped=1, pkts_committed=1, and only the 2 new words are output.
- reset asserted for 1 cycle mid-packet with 2 committed packets buffered → out_wr=0 the cycle after; counters 0; nothing is output until a new packet commits.
